// File: rtl/rom_access_arbiter_pkg.sv
// Shared widths, sequencer state encoding and checksum helper for the
// instruction-ROM access arbiter.
package rom_access_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 18;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  // Checksum accumulation wraps naturally at the word width.
  function automatic logic [DATA_W-1:0] sum_add(input logic [DATA_W-1:0] acc,
                                                input logic [DATA_W-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/rom_blk_sequencer.sv
// Block-read sequencer: issues consecutive ROM reads in cycles the processor
// leaves idle, streams the returned words and accumulates their checksum.
module rom_blk_sequencer
  import rom_access_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_en,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              blk_start,
  input  logic [ADDR_W-1:0] blk_add,
  input  logic [LEN_W-1:0]  blk_len,
  output logic              seq_issue,
  output logic [ADDR_W-1:0] seq_addr,
  output logic              blk_busy,
  output logic              blk_valid,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_done,
  output logic [DATA_W-1:0] blk_sum
);

  seq_state_e        state_r;
  seq_state_e        state_s;
  logic              issue_s;
  logic              start_ok_s;
  logic              last_issue_s;
  logic [ADDR_W-1:0] seq_addr_r;
  logic [LEN_W-1:0]  remaining_r;
  logic              issue_q_r;
  logic              last_issue_r;
  logic              last_ret_r;
  logic              blk_busy_r;
  logic              blk_valid_r;
  logic [DATA_W-1:0] blk_data_r;
  logic              blk_done_r;
  logic [DATA_W-1:0] blk_sum_r;

  // Issue qualification and next-state selection.
  always_comb begin
    issue_s      = (state_r == RUN) & ~cpu_en;
    // busy still covers the final-word return while the FSM is already IDLE
    start_ok_s   = blk_start & ~blk_busy_r & (state_r == IDLE) & (blk_len != {LEN_W{1'b0}});
    last_issue_s = issue_s & (remaining_r == {{(LEN_W-1){1'b0}}, 1'b1});
    state_s      = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (last_issue_s) state_s = DRAIN;
        else              state_s = RUN;
      end
      DRAIN:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Address and remaining-count bookkeeping; held while the processor owns the ROM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_addr_r  <= {ADDR_W{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else if (start_ok_s) begin
      seq_addr_r  <= blk_add;
      remaining_r <= blk_len;
    end else if (issue_s) begin
      seq_addr_r  <= seq_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      remaining_r <= remaining_r - {{(LEN_W-1){1'b0}}, 1'b1};
    end
  end

  // Return path, checksum and completion signalling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_q_r    <= 1'b0;
      last_issue_r <= 1'b0;
      last_ret_r   <= 1'b0;
      blk_busy_r   <= 1'b0;
      blk_valid_r  <= 1'b0;
      blk_data_r   <= {DATA_W{1'b0}};
      blk_done_r   <= 1'b0;
      blk_sum_r    <= {DATA_W{1'b0}};
    end else begin
      issue_q_r    <= issue_s;
      last_issue_r <= last_issue_s;
      last_ret_r   <= last_issue_r;
      blk_valid_r  <= issue_q_r;
      blk_done_r   <= last_ret_r;
      if (issue_q_r) blk_data_r <= rom_inst;
      if (start_ok_s)     blk_sum_r <= {DATA_W{1'b0}};
      else if (issue_q_r) blk_sum_r <= sum_add(blk_sum_r, rom_inst);
      if (start_ok_s)      blk_busy_r <= 1'b1;
      else if (last_ret_r) blk_busy_r <= 1'b0;
    end
  end

  assign seq_issue = issue_s;
  assign seq_addr  = seq_addr_r;
  assign blk_busy  = blk_busy_r;
  assign blk_valid = blk_valid_r;
  assign blk_data  = blk_data_r;
  assign blk_done  = blk_done_r;
  assign blk_sum   = blk_sum_r;

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares the instruction ROM between processor fetch (absolute priority) and
// the block-read sequencer; keeps the processor's view of the ROM undisturbed.
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_add,
  output logic [DATA_W-1:0] cpu_inst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_add,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              blk_start,
  input  logic [ADDR_W-1:0] blk_add,
  input  logic [LEN_W-1:0]  blk_len,
  output logic              blk_busy,
  output logic              blk_valid,
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_done,
  output logic [DATA_W-1:0] blk_sum
);

  logic              seq_issue_s;
  logic [ADDR_W-1:0] seq_addr_s;
  logic              cpu_fetch_r;
  logic [DATA_W-1:0] cpu_hold_r;

  rom_blk_sequencer u_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_en    (cpu_en),
    .rom_inst  (rom_inst),
    .blk_start (blk_start),
    .blk_add   (blk_add),
    .blk_len   (blk_len),
    .seq_issue (seq_issue_s),
    .seq_addr  (seq_addr_s),
    .blk_busy  (blk_busy),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_done  (blk_done),
    .blk_sum   (blk_sum)
  );

  // Processor always wins the ROM port.
  always_comb begin
    rom_en = cpu_en | seq_issue_s;
    if (cpu_en) rom_add = cpu_add;
    else        rom_add = seq_addr_s;
  end

  // Hold the last fetched word so sequencer reads never reach the processor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_fetch_r <= 1'b0;
      cpu_hold_r  <= {DATA_W{1'b0}};
    end else begin
      cpu_fetch_r <= cpu_en;
      if (cpu_fetch_r) cpu_hold_r <= rom_inst;
    end
  end

  assign cpu_inst = cpu_fetch_r ? rom_inst : cpu_hold_r;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomized bench for rom_access_arbiter against a transaction-level model of
// processor fetches and block reads over a behavioural ROM.
module tb_rom_access_arbiter;
  import rom_access_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cpu_en = 1'b0;
  logic [ADDR_W-1:0] cpu_add = '0;
  logic [DATA_W-1:0] cpu_inst;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_add;
  logic [DATA_W-1:0] rom_inst = '0;
  logic              blk_start = 1'b0;
  logic [ADDR_W-1:0] blk_add = '0;
  logic [LEN_W-1:0]  blk_len = '0;
  logic              blk_busy, blk_valid, blk_done;
  logic [DATA_W-1:0] blk_data, blk_sum;

  rom_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .cpu_add(cpu_add),
    .cpu_inst(cpu_inst), .rom_en(rom_en), .rom_add(rom_add), .rom_inst(rom_inst),
    .blk_start(blk_start), .blk_add(blk_add), .blk_len(blk_len),
    .blk_busy(blk_busy), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_done(blk_done), .blk_sum(blk_sum)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [4096];

  // Behavioural ROM: registered output, updated only when enabled.
  always @(posedge clk) if (rom_en) rom_inst <= mem[rom_add];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_left, m_addr, e_len, e_got, ref_sum, e_cpu, e_sum, e_data;
  bit e_busy, e_valid, e_done, e_last, pv;
  int pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_addr = 0; e_len = 0; e_got = 0; ref_sum = 0;
    e_cpu = 0; e_sum = 0; e_data = 0;
    e_busy = 0; e_valid = 0; e_done = 0; e_last = 0; pv = 0; pd = 0;
  endtask

  task automatic check_outputs();
    chk("cpu_inst", cpu_inst, e_cpu);
    chk("blk_busy", blk_busy, e_busy);
    chk("blk_valid", blk_valid, e_valid);
    chk("blk_done", blk_done, e_done);
    chk("blk_sum", blk_sum, e_sum);
    if (e_valid) chk("blk_data", blk_data, e_data);
    if (e_done) chk("final_sum", blk_sum, ref_sum);
  endtask

  // One clock cycle: drive, check arbitration, advance model, check outputs.
  task automatic step(input bit en, input int a, input bit st, input int ba, input int bl);
    bit issue, accept;
    bit nv;
    int nd;
    @(negedge clk);
    cpu_en = en; cpu_add = a[ADDR_W-1:0]; blk_start = st;
    blk_add = ba[ADDR_W-1:0]; blk_len = bl[LEN_W-1:0];
    #1;
    chk("rom_en", rom_en, en | (m_left != 0));
    if (rom_en) chk("rom_add", rom_add, en ? a : m_addr);
    @(posedge clk);
    issue  = (m_left != 0) && !en;
    accept = st && !e_busy && (bl != 0);
    nv = pv; nd = pd;
    pv = issue; pd = mem[m_addr];
    if (issue) begin m_addr = (m_addr + 1) % 4096; m_left--; end
    if (en) e_cpu = mem[a];
    e_done = e_valid && e_last;
    e_valid = nv;
    if (nv) begin
      e_data = nd; e_sum = (e_sum + nd) % (1 << DATA_W);
      e_got++; e_last = (e_got == e_len);
    end else e_last = 0;
    if (accept) begin
      e_busy = 1; e_sum = 0; m_addr = ba; m_left = bl; e_len = bl; e_got = 0;
      ref_sum = 0;
      for (int i = 0; i < bl; i++) ref_sum = (ref_sum + mem[(ba + i) % 4096]) % (1 << DATA_W);
    end else if (e_done) e_busy = 0;
    #1;
    check_outputs();
  endtask

  // mode: 0 processor idle, 1 toggling fetches, 2 random fetches
  task automatic run_to_idle(input int mode, input int limit);
    int n = 0;
    int cyc = 0;
    while ((e_busy || e_done) && n < limit) begin
      cyc++;
      case (mode)
        0:       step(1'b0, 0, 1'b0, 0, 0);
        1:       step(cyc[0], $urandom_range(0, 4095), 1'b0, 0, 0);
        default: step($urandom_range(0, 3) == 0, $urandom_range(0, 4095), 1'b0, 0, 0);
      endcase
      n++;
    end
    if (n >= limit) chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int done_cnt;
    for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk) reset_n = 1'b1;

    // CPU only
    step(1'b1, 12'h005, 1'b0, 0, 0);
    repeat (5) step(1'b0, 0, 1'b0, 0, 0);

    // Idle block read
    step(1'b0, 0, 1'b1, 12'h010, 4);
    run_to_idle(0, 50);

    // Interleave with toggling fetches, counting done pulses
    done_cnt = 0;
    step(1'b1, 12'h0a0, 1'b1, 12'h100, 8);
    for (int i = 0; i < 40 && (e_busy || e_done); i++) begin
      step(i[0], $urandom_range(0, 4095), 1'b0, 0, 0);
      if (blk_done) done_cnt++;
    end
    chk("done_once", done_cnt, 1);

    // Wrap across the top of the address space
    step(1'b0, 0, 1'b1, 12'hFFE, 4);
    run_to_idle(0, 50);

    // Zero length is ignored
    step(1'b0, 0, 1'b1, 12'h020, 0);
    repeat (4) step(1'b0, 0, 1'b0, 0, 0);

    // Overlapping start ignored while busy
    step(1'b0, 0, 1'b1, 12'h200, 6);
    step(1'b0, 0, 1'b0, 0, 0);
    step(1'b0, 0, 1'b1, 12'h300, 3);
    run_to_idle(0, 50);

    // Full 4096-word read with occasional fetches
    step(1'b0, 0, 1'b1, 12'h000, 4096);
    run_to_idle(2, 8000);

    // Reset after two of eight words
    step(1'b0, 0, 1'b1, 12'h040, 8);
    for (int i = 0; i < 20 && e_got < 2; i++) step(1'b0, 0, 1'b0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk) reset_n = 1'b1;
    step(1'b0, 0, 1'b1, 12'h050, 5);
    run_to_idle(1, 50);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int bl;
      bl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      step($urandom_range(0, 1), $urandom_range(0, 4095), $urandom_range(0, 9) == 0,
           $urandom_range(0, 4095), bl);
    end
    run_to_idle(2, 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
